regfile_mp: RTL and testbench

- Parametrised multi-port register file; successor to the single-write, two-read datapath register file.
- Sits between decode (read addresses from instruction fields) and writeback (ALU and load results).
- Adds two write ports, write-to-read bypass, a hard-wired zero register, and a per-register pending scoreboard for in-flight results.
- Adds a sequenced clear engine that zeroes the array one entry per cycle.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_mp_if.sv | 43 ++++
 rtl/regfile_bypass.sv | 38 +++
 rtl/regfile_mp.sv | 134 +++++++++++++
 tb/tb_regfile_mp.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared widths and clear-engine state encoding for regfile_mp.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

    localparam int c_DEF_DW = 32;
    localparam int c_DEF_AW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        DONE = 2'd2
    } clr_state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Brief    : Read, write, issue and clear signals between pipeline and regfile.
// Revision : 1.0
// ============================================================================
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DW  = c_DEF_DW,
    parameter int AW  = c_DEF_AW,
    parameter int NRD = 2
) ();

    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    rpend;

    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DW-1:0]     wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DW-1:0]     wd1;

    logic              iss_v;
    logic [AW-1:0]     iss_a;

    logic              clr_req;
    logic              clr_busy;

    modport master (
        output ra, we0, wa0, wd0, we1, wa1, wd1, iss_v, iss_a, clr_req,
        input  rd, rpend, clr_busy
    );

    modport slave (
        input  ra, we0, wa0, wd0, we1, wa1, wd1, iss_v, iss_a, clr_req,
        output rd, rpend, clr_busy
    );

endinterface : regfile_mp_if
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bypass
// Brief    : One read port: write-to-read forwarding with port 1 first, plus
//            the hard-wired zero register.
// Revision : 1.0
// ============================================================================
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DW       = c_DEF_DW,
    parameter int AW       = c_DEF_AW,
    parameter bit ZERO_REG = 1'b1
) (
    input  wire logic [AW-1:0] i_ra,
    input  wire logic [DW-1:0] i_word,
    input  wire logic          i_we0,
    input  wire logic [AW-1:0] i_wa0,
    input  wire logic [DW-1:0] i_wd0,
    input  wire logic          i_we1,
    input  wire logic [AW-1:0] i_wa1,
    input  wire logic [DW-1:0] i_wd1,
    output logic      [DW-1:0] o_rd
);

    always_comb begin
        o_rd = i_word;
        if (ZERO_REG && (i_ra == '0)) begin
            o_rd = '0;
        end else if (i_we1 && (i_wa1 == i_ra)) begin
            o_rd = i_wd1;
        end else if (i_we0 && (i_wa0 == i_ra)) begin
            o_rd = i_wd0;
        end
    end

endmodule : regfile_bypass
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Two-write, NRD-read register file with bypass, pending
//            scoreboard and a one-entry-per-cycle clear engine.
// Revision : 1.0
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = c_DEF_DW,
    parameter int AW       = c_DEF_AW,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  wire logic   clk,
    input  wire logic   reset,
    regfile_mp_if.slave bus
);

    localparam int            c_DEPTH = 1 << AW;
    localparam logic [AW:0]   c_LAST  = (AW+1)'(c_DEPTH - 1);

    logic [DW-1:0]      r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_pend;

    clr_state_e         r_state;
    logic [AW:0]        r_ptr;
    logic               r_clr_busy;

    logic               w_we0;
    logic               w_we1;
    logic               w_iss;
    logic               w_clr_act;
    logic [AW-1:0]      w_clr_idx;
    logic [NRD*DW-1:0]  w_rd;
    logic [NRD-1:0]     w_rpend;

    // Qualified strobes: the clear engine owns the array while busy, and the
    // zero register swallows writes and issues.
    assign w_we0     = bus.we0   && !r_clr_busy && !(ZERO_REG && (bus.wa0   == '0));
    assign w_we1     = bus.we1   && !r_clr_busy && !(ZERO_REG && (bus.wa1   == '0));
    assign w_iss     = bus.iss_v && !r_clr_busy && !(ZERO_REG && (bus.iss_a == '0));
    assign w_clr_act = (r_state == CLR);
    assign w_clr_idx = r_ptr[AW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_clr_busy <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.clr_req) begin
                        r_state    <= CLR;
                        r_ptr      <= '0;
                        r_clr_busy <= 1'b1;
                    end
                end
                CLR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == c_LAST) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_clr_busy <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Port 1 is written after port 0 so it wins a same-address collision;
    // the issue set comes last so a new issue supersedes a completing write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend <= '0;
        end else if (w_clr_act) begin
            r_mem[w_clr_idx]  <= '0;
            r_pend[w_clr_idx] <= 1'b0;
        end else begin
            if (w_we0) begin
                r_mem[bus.wa0]  <= bus.wd0;
                r_pend[bus.wa0] <= 1'b0;
            end
            if (w_we1) begin
                r_mem[bus.wa1]  <= bus.wd1;
                r_pend[bus.wa1] <= 1'b0;
            end
            if (w_iss) begin
                r_pend[bus.iss_a] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = bus.ra[k*AW +: AW];

        regfile_bypass #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_bypass (
            .i_ra   (w_ra),
            .i_word (r_mem[w_ra]),
            .i_we0  (w_we0),
            .i_wa0  (bus.wa0),
            .i_wd0  (bus.wd0),
            .i_we1  (w_we1),
            .i_wa1  (bus.wa1),
            .i_wd1  (bus.wd1),
            .o_rd   (w_rd[k*DW +: DW])
        );

        assign w_rpend[k] = r_pend[w_ra] &&
                            !((w_we0 && (bus.wa0 == w_ra)) || (w_we1 && (bus.wa1 == w_ra)));
    end : g_rd

    assign bus.rd       = w_rd;
    assign bus.rpend    = w_rpend;
    assign bus.clr_busy = r_clr_busy;

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed vector table, clear/reset sequences and random traffic
//            against an array-based reference model of regfile_mp.
// Revision : 1.0
// ============================================================================
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int c_DW    = 32;
    localparam int c_AW    = 5;
    localparam int c_NRD   = 2;
    localparam int c_DEPTH = 32;

    logic clk;
    logic reset;

    regfile_mp_if #(.DW(c_DW), .AW(c_AW), .NRD(c_NRD)) bus ();

    regfile_mp #(
        .DW       (c_DW),
        .AW       (c_AW),
        .NRD      (c_NRD),
        .ZERO_REG (1'b1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain arrays plus a countdown for the clear engine.
    logic [31:0] m_mem  [c_DEPTH];
    bit          m_pend [c_DEPTH];
    int          m_busy_left;
    int          m_clr_pos;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < c_DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_busy_left = 0;
        m_clr_pos   = 0;
    endtask

    function automatic bit model_busy();
        return m_busy_left > 0;
    endfunction

    function automatic bit model_writes(input logic [4:0] a);
        if (model_busy()) return 1'b0;
        return (bus.we0 && bus.wa0 == a && a != 0) || (bus.we1 && bus.wa1 == a && a != 0);
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 0) return '0;
        if (!model_busy() && bus.we1 && bus.wa1 == a) return bus.wd1;
        if (!model_busy() && bus.we0 && bus.wa0 == a) return bus.wd0;
        return m_mem[a];
    endfunction

    function automatic logic model_rpend(input logic [4:0] a);
        return m_pend[a] && !model_writes(a);
    endfunction

    task automatic model_edge();
        if (m_busy_left > 0) begin
            if (m_clr_pos < c_DEPTH) begin
                m_mem[m_clr_pos]  = '0;
                m_pend[m_clr_pos] = 1'b0;
                m_clr_pos++;
            end
            m_busy_left--;
        end else begin
            if (bus.we0 && bus.wa0 != 0) begin
                m_mem[bus.wa0]  = bus.wd0;
                m_pend[bus.wa0] = 1'b0;
            end
            if (bus.we1 && bus.wa1 != 0) begin
                m_mem[bus.wa1]  = bus.wd1;
                m_pend[bus.wa1] = 1'b0;
            end
            if (bus.iss_v && bus.iss_a != 0) m_pend[bus.iss_a] = 1'b1;
            if (bus.clr_req) begin
                m_busy_left = c_DEPTH + 1;
                m_clr_pos   = 0;
            end
        end
    endtask

    task automatic drive_idle();
        bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
        bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
        bus.iss_v = 1'b0; bus.iss_a = '0;
        bus.clr_req = 1'b0;
    endtask

    task automatic check_outputs();
        logic [4:0] a0, a1;
        a0 = bus.ra[4:0];
        a1 = bus.ra[9:5];
        check("rd0",      bus.rd[31:0],              model_rd(a0));
        check("rd1",      bus.rd[63:32],             model_rd(a1));
        check("rpend0",   32'(bus.rpend[0]),         32'(model_rpend(a0)));
        check("rpend1",   32'(bus.rpend[1]),         32'(model_rpend(a1)));
        check("clr_busy", 32'(bus.clr_busy),         32'(model_busy()));
    endtask

    // Inputs are driven 1 ns after the rising edge; outputs are checked 3 ns later.
    task automatic cycle();
        #3;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic [4:0]  ra0, ra1;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iss_v;
        logic [4:0]  iss_a;
        logic [31:0] e_rd0, e_rd1;
        logic        e_rp0, e_rp1;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_len;
        bit busy_s;
        bit seen_busy;

        //             ra0 ra1 we0 wa0 wd0           we1 wa1 wd1           iss iss_a rd0           rd1           rp0 rp1
        tbl[0] = '{5'd0,  5'd3,  0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'h0,         0, 0};
        tbl[1] = '{5'd7,  5'd7,  1, 5'd7,  32'hAAAA_0001, 0, 5'd0,  32'h0,         0, 5'd0,  32'hAAAA_0001, 32'hAAAA_0001, 0, 0};
        tbl[2] = '{5'd7,  5'd9,  1, 5'd9,  32'h1,         1, 5'd9,  32'h2,         0, 5'd0,  32'hAAAA_0001, 32'h2,         0, 0};
        tbl[3] = '{5'd9,  5'd0,  0, 5'd0,  32'h0,         1, 5'd0,  32'hFFFF_FFFF, 1, 5'd0,  32'h2,         32'h0,         0, 0};
        tbl[4] = '{5'd0,  5'd12, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         1, 5'd12, 32'h0,         32'h0,         0, 0};
        tbl[5] = '{5'd12, 5'd0,  0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'h0,         1, 0};
        tbl[6] = '{5'd12, 5'd7,  1, 5'd12, 32'h55,        0, 5'd0,  32'h0,         0, 5'd0,  32'h55,        32'hAAAA_0001, 0, 0};
        tbl[7] = '{5'd12, 5'd12, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 5'd0,  32'h55,        32'h55,        0, 0};
        tbl[8] = '{5'd12, 5'd12, 0, 5'd0,  32'h0,         1, 5'd12, 32'h66,        1, 5'd12, 32'h66,        32'h66,        0, 0};
        tbl[9] = '{5'd12, 5'd9,  0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 5'd0,  32'h66,        32'h2,         1, 0};

        reset  = 1'b0;
        bus.ra = '0;
        drive_idle();
        model_reset();
        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;
        #3;
        check("busy_after_reset", 32'(bus.clr_busy), 32'h0);

        // Directed vectors, applied back to back from reset.
        for (int i = 0; i < 10; i++) begin
            bus.ra    = {tbl[i].ra1, tbl[i].ra0};
            bus.we0   = tbl[i].we0;  bus.wa0 = tbl[i].wa0; bus.wd0 = tbl[i].wd0;
            bus.we1   = tbl[i].we1;  bus.wa1 = tbl[i].wa1; bus.wd1 = tbl[i].wd1;
            bus.iss_v = tbl[i].iss_v; bus.iss_a = tbl[i].iss_a;
            bus.clr_req = 1'b0;
            #3;
            check($sformatf("vec%0d_rd0", i), bus.rd[31:0],      tbl[i].e_rd0);
            check($sformatf("vec%0d_rd1", i), bus.rd[63:32],     tbl[i].e_rd1);
            check($sformatf("vec%0d_rp0", i), 32'(bus.rpend[0]), 32'(tbl[i].e_rp0));
            check($sformatf("vec%0d_rp1", i), 32'(bus.rpend[1]), 32'(tbl[i].e_rp1));
            @(posedge clk);
            model_edge();
            #1;
        end

        // Preload every non-zero entry and scatter some pending bits.
        for (int i = 1; i < c_DEPTH; i++) begin
            drive_idle();
            bus.ra    = {5'(i), 5'(i - 1)};
            bus.we0   = 1'b1;
            bus.wa0   = 5'(i);
            bus.wd0   = 32'h1000_0000 + 32'(i) * 32'h0101;
            bus.iss_v = 1'b1;
            bus.iss_a = 5'((i * 7) % c_DEPTH);
            cycle();
        end

        // Clear: measure busy length, poke a write and a second request mid-clear.
        drive_idle();
        bus.clr_req = 1'b1;
        cycle();
        busy_len  = 0;
        seen_busy = 1'b0;
        for (int c = 0; c < 60; c++) begin
            drive_idle();
            bus.ra = 10'($urandom);
            if (c == 5) begin
                bus.we0 = 1'b1; bus.wa0 = 5'd31; bus.wd0 = 32'hDEAD_BEEF;
                bus.iss_v = 1'b1; bus.iss_a = 5'd30;
            end
            if (c == 10) bus.clr_req = 1'b1;
            #3;
            busy_s = bus.clr_busy;
            check_outputs();
            @(posedge clk);
            model_edge();
            #1;
            if (busy_s) begin
                busy_len++;
                seen_busy = 1'b1;
            end else if (seen_busy || c > 2) begin
                break;
            end
        end
        check("clr_busy_len", 32'(busy_len), 32'd33);

        drive_idle();
        for (int i = 0; i < c_DEPTH / 2; i++) begin
            bus.ra = {5'(2 * i + 1), 5'(2 * i)};
            #3;
            check($sformatf("cleared_%0d", 2 * i + 1), bus.rd[63:32], 32'h0);
            #(-0);
            cycle_tail();
        end

        // Refill, then abort a clear with an asynchronous reset between edges.
        for (int i = 1; i < c_DEPTH; i++) begin
            drive_idle();
            bus.ra  = {5'(i), 5'(i)};
            bus.we1 = 1'b1; bus.wa1 = 5'(i); bus.wd1 = 32'h00C0_0000 | 32'(i);
            bus.iss_v = 1'b1; bus.iss_a = 5'(c_DEPTH - i);
            cycle();
        end
        drive_idle();
        bus.clr_req = 1'b1;
        cycle();
        drive_idle();
        for (int c = 0; c < 10; c++) cycle();
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check("busy_in_reset", 32'(bus.clr_busy), 32'h0);
        for (int j = 0; j < 3; j++) begin
            bus.ra = {5'(31 - 2 * j), 5'(30 - 2 * j)};
            #1;
            check("rd0_in_reset", bus.rd[31:0],  32'h0);
            check("rd1_in_reset", bus.rd[63:32], 32'h0);
            check("rpend_in_reset", 32'(bus.rpend), 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < c_DEPTH / 2; i++) begin
            bus.ra = {5'(2 * i + 1), 5'(2 * i)};
            cycle();
        end

        // Random traffic over a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            bus.ra      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.we0     = 1'($urandom);
            bus.wa0     = 5'($urandom_range(0, 7));
            bus.wd0     = $urandom;
            bus.we1     = 1'($urandom);
            bus.wa1     = 5'($urandom_range(0, 7));
            bus.wd1     = $urandom;
            bus.iss_v   = 1'($urandom);
            bus.iss_a   = 5'($urandom_range(0, 7));
            bus.clr_req = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Second half of a cycle for loops that did their own sampling.
    task automatic cycle_tail();
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

endmodule : tb_regfile_mp
`default_nettype wire
